idr_fu: RTL

IDR_FU -- requirements
Module: idr_fu

---
 rtl/cpu_params_pkg.sv | 7 +
 rtl/cpu_structs_pkg.sv | 10 +
 rtl/idr_fu_pkg.sv | 15 +
 rtl/idr_fu_if.sv | 25 ++
 rtl/idr_fu.sv | 134 +++++++++++++
 5 files changed

// File: rtl/cpu_params_pkg.sv
// Core-wide sizing constants shared by the execute-stage functional units.
//   RSZ       : architectural register width
//   DIV_STEPS : number of radix-2 iterations for a full-width divide
package cpu_params_pkg;
  localparam int RSZ       = 32;
  localparam int DIV_STEPS = 32;
endpackage

// File: rtl/cpu_structs_pkg.sv
// Core-wide enumerated types.
//   IDR_OP_TYPE : integer divide/remainder operation selector (RV32M subset)
package cpu_structs_pkg;
  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } IDR_OP_TYPE;
endpackage

// File: rtl/idr_fu_pkg.sv
// Helper functions for the integer divide/remainder unit.
//   is_signed_op : DIV/REM treat operands as two's complement
//   mag          : absolute value when sgn is set, raw value otherwise
package idr_fu_pkg;
  import cpu_params_pkg::*;
  import cpu_structs_pkg::*;

  function automatic logic is_signed_op(input IDR_OP_TYPE op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic [RSZ-1:0] mag(input logic [RSZ-1:0] v, input logic sgn);
    return (sgn && v[RSZ-1]) ? (~v + 1'b1) : v;
  endfunction
endpackage

// File: rtl/idr_fu_if.sv
// Execute-stage integer divide/remainder port.
//   Rs1_data  : dividend                 (master -> slave)
//   Rs2_data  : divisor                  (master -> slave)
//   op        : DIV / DIVU / REM / REMU  (master -> slave)
//   start     : request, taken only when the unit is idle
//   quotient  : registered quotient      (slave -> master)
//   remainder : registered remainder     (slave -> master)
//   done      : one-cycle completion pulse
interface IDRFU_intf;
  import cpu_params_pkg::*;
  import cpu_structs_pkg::*;

  logic [RSZ-1:0] Rs1_data;
  logic [RSZ-1:0] Rs2_data;
  IDR_OP_TYPE     op;
  logic           start;
  logic [RSZ-1:0] quotient;
  logic [RSZ-1:0] remainder;
  logic           done;

  modport master (output Rs1_data, Rs2_data, op, start,
                  input  quotient, remainder, done);
  modport slave  (input  Rs1_data, Rs2_data, op, start,
                  output quotient, remainder, done);
endinterface

// File: rtl/idr_fu.sv
// Iterative radix-2 restoring integer divider (RV32M DIV/DIVU/REM/REMU).
// A request taken in IDLE latches operand magnitudes and sign flags, runs
// DIV_STEPS restoring steps in CALC, then fixes signs and publishes both
// quotient and remainder in FIX together with a one-cycle done pulse.
// Divide-by-zero and signed overflow skip CALC and go straight to FIX.
//   clk_in      : clock, rising edge
//   reset_n_in  : synchronous active-low reset
//   idr         : IDRFU_intf slave (operands/op/start in, results/done out)
module idr_fu
  import cpu_params_pkg::*;
  import cpu_structs_pkg::*;
  import idr_fu_pkg::*;
(
  input  logic      clk_in,
  input  logic      reset_n_in,
  IDRFU_intf.slave  idr
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t         r_state;
  logic [5:0]     r_cnt;
  IDR_OP_TYPE     r_op;
  logic [RSZ-1:0] r_dvs;        // divisor magnitude
  logic [RSZ-1:0] r_quo;        // dividend bits shift out MSB-first, quotient bits shift in
  logic [RSZ-1:0] r_rem;        // partial remainder
  logic           r_neg_q;
  logic           r_neg_r;
  logic           r_special;    // result already final, no sign fix
  logic [RSZ-1:0] r_quotient;
  logic [RSZ-1:0] r_remainder;
  logic           r_done;

  // Request decode, only meaningful while IDLE.
  logic           w_sgn;
  logic [RSZ-1:0] w_a_mag;
  logic [RSZ-1:0] w_b_mag;
  logic           w_div0;
  logic           w_ovf;

  always_comb begin
    w_sgn   = is_signed_op(idr.op);
    w_a_mag = mag(idr.Rs1_data, w_sgn);
    w_b_mag = mag(idr.Rs2_data, w_sgn);
    w_div0  = (idr.Rs2_data == '0);
    w_ovf   = w_sgn && (idr.Rs1_data == {1'b1, {(RSZ-1){1'b0}}})
                    && (idr.Rs2_data == '1);
  end

  // One restoring step. The shifted partial remainder needs RSZ+1 bits;
  // one extra bit on the difference gives the borrow that decides the
  // quotient bit.
  logic [RSZ:0]   w_shift;
  logic [RSZ+1:0] w_diff;
  logic           w_qbit;
  logic [RSZ-1:0] w_rem_nxt;
  logic [RSZ-1:0] w_quo_nxt;

  always_comb begin
    w_shift   = {r_rem, r_quo[RSZ-1]};
    w_diff    = {1'b0, w_shift} - {2'b00, r_dvs};
    w_qbit    = ~w_diff[RSZ+1];
    w_rem_nxt = w_qbit ? w_diff[RSZ-1:0] : w_shift[RSZ-1:0];
    w_quo_nxt = {r_quo[RSZ-2:0], w_qbit};
  end

  // Sign fix applies only to real signed iterations.
  logic w_fix_sgn;
  assign w_fix_sgn = is_signed_op(r_op) && !r_special;

  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_op        <= DIV;
      r_dvs       <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_special   <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (idr.start) begin
            r_op    <= idr.op;
            r_dvs   <= w_b_mag;
            r_cnt   <= '0;
            r_neg_q <= idr.Rs1_data[RSZ-1] ^ idr.Rs2_data[RSZ-1];
            r_neg_r <= idr.Rs1_data[RSZ-1];
            if (w_div0) begin
              r_special <= 1'b1;
              r_quo     <= '1;
              r_rem     <= idr.Rs1_data;
              r_state   <= FIX;
            end else if (w_ovf) begin
              r_special <= 1'b1;
              r_quo     <= idr.Rs1_data;
              r_rem     <= '0;
              r_state   <= FIX;
            end else begin
              r_special <= 1'b0;
              r_quo     <= w_a_mag;
              r_rem     <= '0;
              r_state   <= CALC;
            end
          end
        end
        CALC: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'(DIV_STEPS - 1)) r_state <= FIX;
        end
        FIX: begin
          r_quotient  <= (w_fix_sgn && r_neg_q) ? (~r_quo + 1'b1) : r_quo;
          r_remainder <= (w_fix_sgn && r_neg_r) ? (~r_rem + 1'b1) : r_rem;
          r_done      <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign idr.quotient  = r_quotient;
  assign idr.remainder = r_remainder;
  assign idr.done      = r_done;

endmodule
